// File: rtl/deserializer_pkg.sv
// deserializer_pkg: shared widths, FSM state type and length-code helper for the serial link
package deser_pkg;
    localparam int DATA_W  = 16;
    localparam int MOD_W   = 4;
    localparam int MIN_LEN = 3;
    typedef enum logic {IDLE, RECV} state_t;
    // Length code 0 stands for a full DATA_W-bit frame.
    function automatic logic [MOD_W:0] mod_to_len(input logic [MOD_W-1:0] mod);
        return (mod == '0) ? (MOD_W + 1)'(DATA_W) : {1'b0, mod};
    endfunction
endpackage

// File: rtl/deserializer_if.sv
// deserializer_if: serial input and parallel output bundle of the deserializer
//   ser_data_i/ser_data_val_i          : serial bit and its qualifier (MSB first)
//   deser_data_o/deser_data_mod_o      : left-aligned word and length code (0 = full width)
//   deser_data_val_o/deser_err_o       : one-cycle good-frame and runt-drop pulses
interface deserializer_if #(
    parameter int DATA_W = deser_pkg::DATA_W,
    parameter int MOD_W  = deser_pkg::MOD_W
);
    logic              ser_data_i;
    logic              ser_data_val_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [MOD_W-1:0]  deser_data_mod_o;
    logic              deser_data_val_o;
    logic              deser_err_o;
    modport master (
        output ser_data_i, ser_data_val_i,
        input  deser_data_o, deser_data_mod_o, deser_data_val_o, deser_err_o
    );
    modport slave (
        input  ser_data_i, ser_data_val_i,
        output deser_data_o, deser_data_mod_o, deser_data_val_o, deser_err_o
    );
endinterface

// File: rtl/deserializer.sv
// deserializer: reassembles MSB-first serial frames of MIN_LEN..DATA_W bits into a left-aligned word
//   clk_i  : clock, rising edge
//   srst_i : synchronous active-high reset, highest priority
//   bus    : deserializer_if.slave (serial in, word/mod/val/err out, all outputs registered)
module deserializer #(
    parameter int DATA_W  = deser_pkg::DATA_W,
    parameter int MOD_W   = deser_pkg::MOD_W,
    parameter int MIN_LEN = deser_pkg::MIN_LEN
) (
    input logic           clk_i,
    input logic           srst_i,
    deserializer_if.slave bus
);
    import deser_pkg::*;
    localparam int CW = MOD_W + 1;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic              val_q, val_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] shifted;
    logic [CW-1:0]     cnt_inc;
    logic [CW-1:0]     close_len;
    logic              close;
    always_comb begin
        shifted   = {shreg_q[DATA_W-2:0], bus.ser_data_i};
        cnt_inc   = cnt_q + 1'b1;
        // A frame ends on a gap, or on its DATA_W-th bit without needing a gap.
        close     = (state_q == RECV) && (!bus.ser_data_val_i || cnt_inc == CW'(DATA_W));
        close_len = bus.ser_data_val_i ? cnt_inc : cnt_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        mod_d     = mod_q;
        val_d     = 1'b0;
        err_d     = 1'b0;
        if (close) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            if (close_len >= CW'(MIN_LEN)) begin
                data_d = (bus.ser_data_val_i ? shifted : shreg_q) << (CW'(DATA_W) - close_len);
                mod_d  = close_len[MOD_W-1:0];
                val_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.ser_data_val_i) begin
            // From IDLE the register and count are already zero, so this also starts a frame.
            state_d = RECV;
            cnt_d   = cnt_inc;
            shreg_d = shifted;
        end
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end
    assign bus.deser_data_o     = data_q;
    assign bus.deser_data_mod_o = mod_q;
    assign bus.deser_data_val_o = val_q;
    assign bus.deser_err_o      = err_q;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: randomized and directed frames checked every cycle against a frame-level model
module tb_deserializer;
    import deser_pkg::*;
    logic clk = 1'b0;
    logic srst = 1'b1;
    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int ev_kind[int];
    logic [15:0] ev_data[int];
    logic [3:0] ev_mod[int];
    int dut_val_edges[$];
    logic [15:0] cur_d = '0;
    logic [3:0] cur_m = '0;
    always #5 clk = ~clk;
    deserializer_if bus ();
    deserializer dut (.clk_i(clk), .srst_i(srst), .bus(bus.slave));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask
    // Expected outputs per edge: 1 = good frame, 2 = runt, 3 = reset.
    always @(posedge clk) begin
        int k;
        edge_n++;
        #1;
        k = ev_kind.exists(edge_n) ? ev_kind[edge_n] : 0;
        if (k == 3) begin
            cur_d = '0;
            cur_m = '0;
        end
        if (k == 1) begin
            cur_d = ev_data[edge_n];
            cur_m = ev_mod[edge_n];
        end
        if (bus.deser_data_val_o === 1'b1) dut_val_edges.push_back(edge_n);
        chk("val", 32'(bus.deser_data_val_o), 32'(k == 1));
        chk("err", 32'(bus.deser_err_o), 32'(k == 2));
        chk("data", 32'(bus.deser_data_o), 32'(cur_d));
        chk("mod", 32'(bus.deser_data_mod_o), 32'(cur_m));
    end
    task automatic step(input logic r, input logic v, input logic b);
        @(negedge clk);
        srst = r;
        bus.ser_data_val_i = v;
        bus.ser_data_i = b;
        if (r) ev_kind[edge_n + 1] = 3;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom));
    endtask
    // Sends the top n bits of word; a recorded frame closes on its 16th bit or on the following gap.
    task automatic send(input logic [15:0] word, input int n, input bit rec);
        int s;
        int ce;
        logic [15:0] mask;
        s = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, word[15 - i]);
            if (i == 0) s = edge_n + 1;
        end
        if (!rec) return;
        ce = (n == 16) ? s + 15 : s + n;
        mask = 16'hFFFF << (16 - n);
        if (n >= MIN_LEN) begin
            ev_kind[ce] = 1;
            ev_data[ce] = word & mask;
            ev_mod[ce] = 4'(n % 16);
        end else begin
            ev_kind[ce] = 2;
        end
    endtask
    initial begin
        int n;
        logic [3:0] m;
        logic [15:0] w;
        bus.ser_data_val_i = 1'b0;
        bus.ser_data_i = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(1);
        send(16'hA5C3, 16, 1'b1);
        idle(2);
        chk("lit_a5c3_data", 32'(bus.deser_data_o), 32'h0000A5C3);
        chk("lit_a5c3_mod", 32'(bus.deser_data_mod_o), 32'd0);
        send(16'hB000, 5, 1'b1);
        idle(2);
        chk("lit_b000_data", 32'(bus.deser_data_o), 32'h0000B000);
        chk("lit_b000_mod", 32'(bus.deser_data_mod_o), 32'd5);
        dut_val_edges.delete();
        send(16'hFFFF, 16, 1'b1);
        send(16'h0001, 16, 1'b1);
        idle(2);
        chk("lit_b2b_count", 32'(dut_val_edges.size()), 32'd2);
        if (dut_val_edges.size() == 2)
            chk("lit_b2b_spacing", 32'(dut_val_edges[1] - dut_val_edges[0]), 32'd16);
        chk("lit_b2b_data", 32'(bus.deser_data_o), 32'h00000001);
        send(16'hC000, 2, 1'b1);
        idle(2);
        chk("lit_runt_data", 32'(bus.deser_data_o), 32'h00000001);
        chk("lit_runt_mod", 32'(bus.deser_data_mod_o), 32'd0);
        send(16'hFE00, 7, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        send(16'hE000, 3, 1'b1);
        idle(2);
        chk("lit_abort_data", 32'(bus.deser_data_o), 32'h0000E000);
        chk("lit_abort_mod", 32'(bus.deser_data_mod_o), 32'd3);
        chk("lit_mod_to_len0", 32'(mod_to_len(4'd0)), 32'd16);
        chk("lit_mod_to_len5", 32'(mod_to_len(4'd5)), 32'd5);
        for (int f = 0; f < 1000; f++) begin
            w = 16'($urandom);
            m = 4'($urandom_range(2, 15));
            if (m == 4'd2) m = 4'd0;
            n = (m == 4'd0) ? 16 : int'(m);
            send(w, n, 1'b1);
            idle((n == 16) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3)));
        end
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel receiver for the team's bit-serial link: it reassembles frames produced by the serializer (MSB first, 3..16 bits, contiguous valid) into a left-aligned 16-bit word plus a length code, with a one-cycle valid pulse. It sits at the receive end of the link, ahead of any word-level consumer, and mirrors the serializer's `data_i`/`data_mod_i` encoding.

## Interface
- `DATA_W`, default 16: maximum frame length and output word width.
- `MOD_W`, default 4: width of the length code, equal to `$clog2(DATA_W)`.
- `MIN_LEN`, default 3: shortest legal frame, in bits.
- `clk_i`, input, 1: the only clock. All logic is on the rising edge.
- `srst_i`, input, 1: synchronous, active-high reset.
- `ser_data_i`, input, 1: serial data bit, MSB of the frame first.
- `ser_data_val_i`, input, 1: qualifies `ser_data_i`; stays high for the whole frame.
- `deser_data_o`, output, `DATA_W`: received word, left-aligned. The first bit lands in [15]; unused low bits are 0.
- `deser_data_mod_o`, output, `MOD_W`: frame length N mod 16. A value of 0 means 16 bits.
- `deser_data_val_o`, output, 1: one-cycle pulse; data and mod are valid in that cycle.
- `deser_err_o`, output, 1: one-cycle pulse when a runt frame is dropped.

## Operation
- Two-state FSM.
  - IDLE, with bit count 0.
  - RECV, with bit count 1..15.
- IDLE:
  - `ser_data_val_i`=1 → shift the bit into the shift register, cnt=1, go to RECV.
  - `ser_data_val_i`=0 → stay in IDLE.
- RECV, `ser_data_val_i`=1:
  - Shift in the bit; cnt+1.
  - If this is bit 16 → close the frame with N=16 and go to IDLE. The frame is delimited by count, so no gap is needed.
- RECV, `ser_data_val_i`=0: close the frame with N=cnt and go to IDLE.
- Frame close with N≥`MIN_LEN`:
  - Load `deser_data_o` = shift register << (16−N), so bit 1 lands in [15] and the low bits are zero.
  - Load `deser_data_mod_o` = N[3:0]; pulse `deser_data_val_o`.
- Frame close with N<`MIN_LEN`:
  - Pulse `deser_err_o`; do not pulse `deser_data_val_o`.
  - `deser_data_o` and `deser_data_mod_o` are unchanged.
- `deser_data_o` and `deser_data_mod_o` hold their last value until the next good frame.
- The shift register is cleared whenever the FSM enters IDLE, so no stale bits carry into the next frame.
- Bits with `ser_data_val_i`=0 are ignored. `ser_data_i` is a don't-care in those cycles.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE and cnt=0.
  - `srst_i` takes priority over every other event.
  - Reset mid-frame discards the partial frame; no val or err pulse is produced.
- Let bit k of a frame be sampled at clock edge E_k.
- 16-bit frame: outputs are registered at E_16, so `deser_data_val_o` is high in the cycle after the last bit.
- N-bit frame (N<16): the gap is sampled at E_{N+1} and outputs are registered there.
  - Latency is one cycle longer than for a 16-bit frame.
- Back-to-back 16-bit frames with no gap:
  - Bit 1 of frame 2 is accepted at E_17 while frame 1's val pulse is visible.
  - Consecutive val pulses are exactly 16 cycles apart.
- A frame of N<16 bits must be followed by at least one idle cycle. Without one, the frames merge (the transmitter guarantees the gap).
- val and err are never asserted in the same cycle. Each is exactly one cycle wide.
- No backpressure: the consumer must accept data on the val pulse.

## Structure
- Package `deser_pkg`:
  - `DATA_W`, `MOD_W`, `MIN_LEN` defaults.
  - `state_t` enum {IDLE, RECV}.
  - Helper function `mod_to_len(mod)` (0→16), shared with the serializer bench.
- Single module; no sub-module is needed.
- A registered top-level wrapper `deserializer_wrapper`, for Fmax measurement, registers every port once. It is a separate file and not part of this block.

## Test plan
- 16 bits of 0xA5C3, contiguous → `deser_data_o`=0xA5C3, mod=0, one val pulse in the cycle after E_16, err=0.
- Bits 1,0,1,1,0 then a gap → `deser_data_o`=0xB000, mod=5, val pulse one cycle after the gap is sampled.
- Two contiguous 16-bit frames 0xFFFF then 0x0001 → two val pulses 16 cycles apart, with correct words in order.
- Bits 1,1 then a gap → err pulse, no val, and `deser_data_o`/`deser_data_mod_o` keep their previous values.
- 7 bits of 1, then `srst_i` for one cycle, then bits 1,1,1 and a gap → no output for the aborted frame, then 0xE000 with mod=3.
- Loopback from the serializer with random `data_i` and `data_mod_i` in {0, 3..15}, 1000 frames → every word and mod matches the masked input and err never fires.
